// File: rtl/mp_shared_mem_arb.sv
// ---------------------------------------------------------------------------
// mp_shared_mem_arb
// N-core shared-memory subsystem. Each core presents a request channel. An
// arbiter grants one access per cycle to a single-port memory. Responses come
// back on a shared bus that is tagged with the index of the owning core.
//
// Optional feature (compile-time macro): MP_MEM_PARITY_EN
//   defined   : each word stores an even-parity bit. The bit is XORed with the
//               writer's par_inj_i bit. A read whose stored parity does not
//               match the recomputed parity raises perr_o together with rvalid_o.
//   undefined : no parity storage. par_inj_i is ignored and perr_o is tied 0.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   req_i          in   [NCORES]     per-core request, held until granted
//   we_i           in   [NCORES]     per-core 1=write 0=read
//   addr_i         in   [NCORES*AW]  core k address at [k*AW +: AW]
//   wdata_i        in   [NCORES*DW]  core k write data at [k*DW +: DW]
//   par_inj_i      in   [NCORES]     flip stored parity on write (parity build only)
//   gnt_o          out  [NCORES]     one-hot-or-zero grant, combinational
//   rvalid_o       out  response valid, single-cycle pulse
//   rid_o          out  [CW]         core index owning the response
//   rdata_o        out  [DW]         read data, or write data echoed for writes
//   conflict_cnt_o out  [16]         saturating count of cycles with >1 request
//   perr_o         out  parity error on the response
// ---------------------------------------------------------------------------
module mp_shared_mem_arb #(
  parameter int NCORES = 4,
  parameter int AW     = 11,
  parameter int DW     = 8,
  parameter int LAT    = 1,
  parameter int RR     = 1,
  localparam int CW    = $clog2(NCORES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    req_i,
  input  logic [NCORES-1:0]    we_i,
  input  logic [NCORES*AW-1:0] addr_i,
  input  logic [NCORES*DW-1:0] wdata_i,
  input  logic [NCORES-1:0]    par_inj_i,
  output logic [NCORES-1:0]    gnt_o,
  output logic                 rvalid_o,
  output logic [CW-1:0]        rid_o,
  output logic [DW-1:0]        rdata_o,
  output logic [15:0]          conflict_cnt_o,
  output logic                 perr_o
);

`ifdef MP_MEM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  logic [CW-1:0] ptr_q, ptr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          found;
  logic [CW-1:0] sel;
  int            cand;

  logic [AW-1:0] acc_addr;
  logic          acc_we;
  logic [DW-1:0] acc_wdata;
  logic [MW-1:0] wword, rword;
  logic [DW-1:0] rd_d;

  // Not reset: contents survive rst_n.
  logic [MW-1:0] mem_q [0:(1<<AW)-1];

  logic          vld_q [0:LAT];
  logic [CW-1:0] id_q  [0:LAT];
  logic [DW-1:0] dat_q [0:LAT];

  // Arbiter. In round-robin mode the search starts at ptr_q and wraps.
  // Otherwise the lowest-index requester wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    gnt_o = '0;
    for (int i = 0; i < NCORES; i++) begin
      cand = (RR != 0) ? (int'(ptr_q) + i) % NCORES : i;
      if (!found && req_i[CW'(cand)]) begin
        found = 1'b1;
        sel   = CW'(cand);
      end
    end
    if (found) gnt_o[sel] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if ((RR != 0) && found)
      ptr_d = (int'(sel) == NCORES - 1) ? '0 : sel + 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (($countones(req_i) > 1) && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  assign acc_addr  = addr_i[int'(sel)*AW +: AW];
  assign acc_we    = we_i[sel];
  assign acc_wdata = wdata_i[int'(sel)*DW +: DW];
  assign rword     = mem_q[acc_addr];
  // Writes echo their own data. Reads see every write committed at earlier edges.
  assign rd_d      = acc_we ? acc_wdata : rword[DW-1:0];

`ifdef MP_MEM_PARITY_EN
  logic perr_d;
  logic perr_q [0:LAT];

  assign wword  = {(^acc_wdata) ^ par_inj_i[sel], acc_wdata};
  assign perr_d = !acc_we && (rword[DW] != (^rword[DW-1:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= LAT; s++) perr_q[s] <= 1'b0;
    end else begin
      if (found) perr_q[0] <= perr_d;
      for (int s = 1; s <= LAT; s++) perr_q[s] <= perr_q[s-1];
    end
  end

  assign perr_o = perr_q[LAT];
`else
  logic unused_par;

  assign wword      = acc_wdata;
  assign unused_par = ^par_inj_i;
  assign perr_o     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (found && acc_we) mem_q[acc_addr] <= wword;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Stage 0 captures the access at the accept edge. Stages 1..LAT then delay
  // it, so rvalid_o rises at accept edge + LAT. Reset flushes in-flight responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= LAT; s++) begin
        vld_q[s] <= 1'b0;
        id_q[s]  <= '0;
        dat_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= found;
      if (found) begin
        id_q[0]  <= sel;
        dat_q[0] <= rd_d;
      end
      for (int s = 1; s <= LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
    end
  end

  assign rvalid_o       = vld_q[LAT];
  assign rid_o          = id_q[LAT];
  assign rdata_o        = dat_q[LAT];
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_mp_shared_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_mp_shared_mem_arb
// Two instances share clk and rst_n.
//   dut 0 : round-robin, LAT=1
//   dut 1 : fixed priority, LAT=3
// The reference model keeps three things: a word-level memory image, a
// response schedule indexed by cycle number, and the arbitration rules
// written as plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_mp_shared_mem_arb;

`ifdef MP_MEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req [2];
  logic [3:0]  we [2];
  logic [3:0]  pinj [2];
  logic [43:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  gnt [2];
  logic        rvalid [2];
  logic        perr [2];
  logic [1:0]  rid [2];
  logic [7:0]  rdata [2];
  logic [15:0] ccnt [2];

  always #5 clk = ~clk;

  mp_shared_mem_arb #(.NCORES(4), .AW(11), .DW(8), .LAT(1), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .par_inj_i(pinj[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rid_o(rid[0]), .rdata_o(rdata[0]), .conflict_cnt_o(ccnt[0]), .perr_o(perr[0]));

  mp_shared_mem_arb #(.NCORES(4), .AW(11), .DW(8), .LAT(3), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .par_inj_i(pinj[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rid_o(rid[1]), .rdata_o(rdata[1]), .conflict_cnt_o(ccnt[1]), .perr_o(perr[1]));

  int lat [2] = '{1, 3};
  int rr  [2] = '{1, 0};

  // Reference model state.
  logic [7:0] mdat [2][2048];
  bit         mkn  [2][2048];
  bit         minj [2][2048];
  bit         sv   [2][8];
  int         sid  [2][8];
  logic [7:0] sdat [2][8];
  bit         skn  [2][8];
  bit         sper [2][8];
  int mptr [2];
  int mcnt [2];
  int g    [2];
  int cyc;
  int n_vec, n_err;

  function automatic int mgrant(int d);
    int k;
    for (int i = 0; i < 4; i++) begin
      k = (rr[d] != 0) ? (mptr[d] + i) % 4 : i;
      if (req[d][k]) return k;
    end
    return -1;
  endfunction

  task automatic set_core(int d, int k, bit r, bit w, int a, int wd, bit inj);
    req[d][k]            = r;
    we[d][k]             = w;
    addr[d][k*11 +: 11]  = 11'(a);
    wdata[d][k*8 +: 8]   = 8'(wd);
    pinj[d][k]           = inj;
  endtask

  task automatic clear_all();
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; we[d] = '0; pinj[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
  endtask

  // One clock cycle. Inputs are set beforehand, at the falling edge.
  task automatic cycle();
    logic [3:0] eg;
    int k, a, s;
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d] = mgrant(d);
      eg = '0;
      if (g[d] >= 0) eg[g[d]] = 1'b1;
      n_vec++;
      if (gnt[d] !== eg) begin
        n_err++;
        $display("FAIL gnt dut%0d cyc%0d: got %b want %b", d, cyc, gnt[d], eg);
      end
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if ($countones(req[d]) > 1 && mcnt[d] < 65535) mcnt[d]++;
      k = g[d];
      if (k >= 0) begin
        a = int'(addr[d][k*11 +: 11]);
        s = (cyc + lat[d]) % 8;
        sv[d][s]  = 1'b1;
        sid[d][s] = k;
        if (we[d][k]) begin
          mdat[d][a] = wdata[d][k*8 +: 8];
          mkn[d][a]  = 1'b1;
          minj[d][a] = pinj[d][k];
          sdat[d][s] = wdata[d][k*8 +: 8];
          skn[d][s]  = 1'b1;
          sper[d][s] = 1'b0;
        end else begin
          sdat[d][s] = mdat[d][a];
          skn[d][s]  = mkn[d][a];
          sper[d][s] = PAR_ON & minj[d][a];
        end
        if (rr[d] != 0) mptr[d] = (k + 1) % 4;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      s = cyc % 8;
      n_vec++;
      if (rvalid[d] !== sv[d][s]) begin
        n_err++;
        $display("FAIL rvalid dut%0d cyc%0d: got %b want %b", d, cyc, rvalid[d], sv[d][s]);
      end
      if (sv[d][s]) begin
        n_vec++;
        if (rid[d] !== 2'(sid[d][s])) begin
          n_err++;
          $display("FAIL rid dut%0d cyc%0d: got %0d want %0d", d, cyc, rid[d], sid[d][s]);
        end
        if (skn[d][s]) begin
          n_vec++;
          if (rdata[d] !== sdat[d][s]) begin
            n_err++;
            $display("FAIL rdata dut%0d cyc%0d: got %h want %h", d, cyc, rdata[d], sdat[d][s]);
          end
          n_vec++;
          if (perr[d] !== sper[d][s]) begin
            n_err++;
            $display("FAIL perr dut%0d cyc%0d: got %b want %b", d, cyc, perr[d], sper[d][s]);
          end
        end
      end
      n_vec++;
      if (ccnt[d] !== 16'(mcnt[d])) begin
        n_err++;
        $display("FAIL conflict_cnt dut%0d cyc%0d: got %0d want %0d", d, cyc, ccnt[d], mcnt[d]);
      end
      sv[d][s] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 8; s++) sv[d][s] = 1'b0;
      mptr[d] = 0;
      mcnt[d] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (rvalid[d] !== 1'b0) begin n_err++; $display("FAIL reset_rvalid dut%0d: got %b want 0", d, rvalid[d]); end
      n_vec++; if (rid[d] !== 2'd0) begin n_err++; $display("FAIL reset_rid dut%0d: got %0d want 0", d, rid[d]); end
      n_vec++; if (rdata[d] !== 8'h00) begin n_err++; $display("FAIL reset_rdata dut%0d: got %h want 00", d, rdata[d]); end
      n_vec++; if (ccnt[d] !== 16'd0) begin n_err++; $display("FAIL reset_cnt dut%0d: got %0d want 0", d, ccnt[d]); end
      n_vec++; if (perr[d] !== 1'b0) begin n_err++; $display("FAIL reset_perr dut%0d: got %b want 0", d, perr[d]); end
      n_vec++; if (gnt[d] !== 4'b0) begin n_err++; $display("FAIL reset_gnt dut%0d: got %b want 0000", d, gnt[d]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    set_core(0, 0, 1, 1, 'h010, 'h5A, 0);
    cycle();
    set_core(0, 0, 1, 0, 'h010, 0, 0);
    cycle();
    n_vec++;
    if (rvalid[0] !== 1'b1 || rid[0] !== 2'd0 || rdata[0] !== 8'h5A) begin
      n_err++; $display("FAIL wr_echo: got v=%b id=%0d d=%h want v=1 id=0 d=5a", rvalid[0], rid[0], rdata[0]);
    end
    set_core(0, 0, 0, 0, 'h010, 0, 0);
    cycle();
    n_vec++;
    if (rvalid[0] !== 1'b1 || rid[0] !== 2'd0 || rdata[0] !== 8'h5A) begin
      n_err++; $display("FAIL rd_after_wr: got v=%b id=%0d d=%h want v=1 id=0 d=5a", rvalid[0], rid[0], rdata[0]);
    end
    cycle();
    n_vec++;
    if (rvalid[0] !== 1'b0) begin n_err++; $display("FAIL rvalid_pulse: got %b want 0", rvalid[0]); end
  endtask

  task automatic test_rr_all();
    logic [3:0] e;
    apply_reset();
    for (int k = 0; k < 4; k++) set_core(0, k, 1, 0, 'h010, 0, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      e = 4'b0001 << (i % 4);
      n_vec++;
      if (gnt[0] !== e) begin n_err++; $display("FAIL rr_order step%0d: got %b want %b", i, gnt[0], e); end
      cycle();
    end
    n_vec++;
    if (ccnt[0] !== 16'd8) begin n_err++; $display("FAIL rr_conflicts: got %0d want 8", ccnt[0]); end
    clear_all();
    repeat (2) cycle();
  endtask

  task automatic test_fixed();
    set_core(1, 1, 1, 0, 'h020, 0, 0);
    set_core(1, 3, 1, 0, 'h020, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (gnt[1] !== 4'b0010) begin n_err++; $display("FAIL fixed_prio step%0d: got %b want 0010", i, gnt[1]); end
      cycle();
    end
    clear_all();
    repeat (4) cycle();
  endtask

  task automatic test_lat3_maxaddr();
    set_core(1, 2, 1, 1, 'h7FF, 'hC3, 0);
    cycle();
    set_core(1, 2, 1, 0, 'h7FF, 0, 0);
    cycle();
    set_core(1, 2, 0, 0, 'h7FF, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_vec++;
      if (rvalid[1] !== ((i == 2) || (i == 3))) begin
        n_err++; $display("FAIL lat3_timing i=%0d: got %b want %b", i, rvalid[1], (i == 2) || (i == 3));
      end
      if (i == 3) begin
        n_vec++;
        if (rid[1] !== 2'd2 || rdata[1] !== 8'hC3) begin
          n_err++; $display("FAIL lat3_data: got id=%0d d=%h want id=2 d=c3", rid[1], rdata[1]);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    set_core(1, 1, 1, 1, 'h030, 'h66, 0);
    cycle();
    set_core(1, 1, 0, 0, 'h030, 0, 0);
    repeat (4) cycle();
    set_core(1, 1, 1, 0, 'h030, 0, 0);
    set_core(0, 0, 1, 0, 'h010, 0, 0);
    cycle();
    clear_all();
    cycle();
    n_vec++;
    if (rvalid[0] !== 1'b1) begin n_err++; $display("FAIL pre_reset_rvalid: got %b want 1", rvalid[0]); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (rvalid[0] !== 1'b0) begin n_err++; $display("FAIL async_drop: got %b want 0", rvalid[0]); end
    apply_reset();
    seen = 0;
    repeat (4) begin
      cycle();
      if (rvalid[1] === 1'b1) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL dropped_resp: got %0d responses want 0", seen); end
    set_core(1, 1, 1, 0, 'h030, 0, 0);
    cycle();
    clear_all();
    for (int i = 1; i <= 3; i++) begin
      cycle();
      if (i == 3) begin
        n_vec++;
        if (rvalid[1] !== 1'b1 || rdata[1] !== 8'h66) begin
          n_err++; $display("FAIL retained_mem: got v=%b d=%h want v=1 d=66", rvalid[1], rdata[1]);
        end
      end
    end
  endtask

  task automatic test_parity();
    set_core(0, 3, 1, 1, 'h020, 'h0F, 1);
    cycle();
    set_core(0, 3, 1, 0, 'h020, 0, 0);
    cycle();
    n_vec++;
    if (rvalid[0] !== 1'b1 || perr[0] !== 1'b0) begin
      n_err++; $display("FAIL par_wr: got v=%b perr=%b want v=1 perr=0", rvalid[0], perr[0]);
    end
    set_core(0, 3, 0, 0, 'h020, 0, 0);
    cycle();
    n_vec++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 8'h0F || perr[0] !== PAR_ON) begin
      n_err++; $display("FAIL par_rd: got v=%b d=%h perr=%b want v=1 d=0f perr=%b", rvalid[0], rdata[0], perr[0], PAR_ON);
    end
    cycle();
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          if (g[d] == k || !req[d][k]) begin
            r = $urandom_range(0, 8);
            if (g[d] == k || $urandom_range(0, 2) == 0)
              set_core(d, k, (g[d] == k) ? 1'($urandom_range(0, 1)) : 1'b1, 1'($urandom_range(0, 1)),
                       (r == 8) ? 'h7FF : r, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
          end
        end
      end
      cycle();
    end
    clear_all();
    repeat (5) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0; mcnt[d] = 0; g[d] = -1;
    end
    clear_all();
    test_reset();
    test_write_read();
    test_rr_all();
    test_fixed();
    test_lat3_maxaddr();
    test_reset_midop();
    test_parity();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
